universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
Parametrised successor to the single-bit serial-in/serial-out shift register used behind the tt_um wrapper.
- Generalised to WIDTH bits.
- Adds hold, shift, rotate and parallel-load modes, plus direction control.
- Parallel read-back of the register.
- Shift counter that strobes once per completed word.
- Sits between the pad-level wrapper (ui_in/uo_out) and serial links that need framed word boundaries.

Parameters:
WIDTH, 8, register length in bits; legal range 2..32.
RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  clock enable; when 0 all state holds.
mode  input  2  00 hold, 01 shift, 10 rotate, 11 parallel load.
leftright  input  1  1 = left (toward MSB), 0 = right (toward LSB).
in  input  1  serial data input, used in shift mode only.
load_data  input  WIDTH  parallel load value, used in mode 11.
out  output  1  serial output: q[WIDTH-1] when leftright=1, q[0] when leftright=0 (combinational mux of registered q).
q  output  WIDTH  register contents.
shift_count  output  CW  shifts/rotates since last word boundary; CW = clog2(WIDTH).
word_done  output  1  one-cycle registered strobe; high in the cycle after the WIDTH-th shift/rotate.

Behaviour:
Clocking and reset:
- Single clock domain, all state updates on the rising clock edge.
- Reset is synchronous and active-high, and has priority over enable and mode.
- Reset values: q=RESET_VALUE, shift_count=0, word_done=0; out follows q per leftright.

When enable=0:
- q and shift_count hold.
- word_done is forced to 0 next edge; the strobe never stretches.

When enable=1, per mode:
- 00 hold: q and count unchanged; word_done<=0.
- 01 shift, left: q<={q[WIDTH-2:0],in}.
- 01 shift, right: q<={in,q[WIDTH-1:1]}.
- 10 rotate, left: q<={q[WIDTH-2:0],q[WIDTH-1]}.
- 10 rotate, right: q<={q[0],q[WIDTH-1:1]}.
- 11 load: q<=load_data; shift_count<=0; word_done<=0.

Counter, for modes 01/10:
- If shift_count==WIDTH-1: shift_count<=0, word_done<=1.
- Otherwise: shift_count<=shift_count+1, word_done<=0.
- Counter never exceeds WIDTH-1. When WIDTH is a power of two it wraps naturally; otherwise the explicit compare forces wrap to 0.
- A direction change mid-word does not clear the counter.
- Mixing shift and rotate cycles within a word counts both.

Other rules:
- Latency: q updates one edge after the command; out reflects the new q in the same cycle it updates; out also changes immediately when leftright toggles.
- A load in the same cycle the count would have reached WIDTH suppresses word_done.
- Reset mid-word abandons the partial word: no strobe, count=0.
- No X propagation: every register has a defined reset value.

Optional Feature:
Macro: SSR_PARITY_EN.
Defined:
- Adds output port parity (1 bit) = registered even parity of q, i.e. XOR of all q bits, updated on the same edge as q.
- parity reset value = XOR of RESET_VALUE.
- Holds when enable=0.
Not defined:
- parity port and its register are absent.
- All other behaviour is identical.

Test Plan:
WIDTH=8, RESET_VALUE=0 unless stated.
1. Reset: assert reset 2 cycles with enable=1, mode=01, in=1 -> q=0x00, shift_count=0, word_done=0, out=0 after the edge.
2. Load then left shift:
   - mode=11, load_data=0xA5, then 8 cycles mode=01, leftright=1, in = 0x3C bits MSB first.
   - out sequence 1,0,1,0,0,1,0,1.
   - Final q=0x3C; shift_count reads 1..7 then 0; word_done high exactly one cycle, after the 8th shift.
3. Rotate right:
   - Load 0x81, mode=10, leftright=0.
   - After 1 edge q=0xC0; after 8 edges q=0x81 with word_done pulse.
   - Toggle leftright mid-word -> count continues, no early strobe.
4. Enable gating:
   - After 4 shifts, drop enable 3 cycles -> q and shift_count=4 held, word_done=0.
   - Resume -> strobe arrives 3 cycles later than the ungated run.
5. Boundary and mid-operation events:
   - Load on the cycle count=7 with mode=11 -> q=load_data, count=0, no word_done.
   - Reset at count=5 -> q=0, count=0, no strobe.
   - WIDTH=5 rerun -> strobe every 5 shifts, count wraps 4->0.
6. SSR_PARITY_EN defined:
   - Load 0x07 -> parity=1.
   - Left shift with in=1 -> q=0x0F, parity=0.
   - Reset -> parity=0.
   - Without the macro, elaboration shows no parity port.

Source files
------------

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_register
//  Description : WIDTH-bit universal shift register with hold, shift, rotate
//                and parallel-load modes, left/right direction control,
//                parallel read-back and a word-boundary shift counter that
//                emits a one-cycle strobe after every WIDTH-th shift/rotate.
//
//  Ports       : clock       - rising-edge clock
//                reset       - synchronous, active-high reset
//                enable      - clock enable; 0 holds all state
//                mode        - 00 hold, 01 shift, 10 rotate, 11 parallel load
//                leftright   - 1 = toward MSB, 0 = toward LSB
//                in          - serial input (shift mode only)
//                load_data   - parallel load value (mode 11)
//                out         - serial output, q[WIDTH-1] (left) or q[0] (right)
//                q           - register contents
//                shift_count - shifts/rotates since last word boundary
//                word_done   - registered strobe after the WIDTH-th shift/rotate
//                parity      - registered XOR of q (only with SSR_PARITY_EN)
//
//  Options     : define SSR_PARITY_EN to add the registered parity output.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     leftright,
    input  logic                     in,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     out,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] shift_count,
    output logic                     word_done
`ifdef SSR_PARITY_EN
    ,
    output logic                     parity
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0]    c_MODE_HOLD   = 2'b00;
    localparam logic [1:0]    c_MODE_SHIFT  = 2'b01;
    localparam logic [1:0]    c_MODE_ROTATE = 2'b10;
    localparam logic [1:0]    c_MODE_LOAD   = 2'b11;

    // Explicit terminal count so non-power-of-two widths still wrap at WIDTH.
    localparam logic [CW-1:0] c_LAST_COUNT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_ONE         = CW'(1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_word_done;

    logic [WIDTH-1:0] w_q_d;
    logic [CW-1:0]    w_cnt_d;
    logic             w_word_done_d;

    // Next-state logic. word_done defaults low so the strobe can never
    // stretch past one cycle, regardless of enable or mode.
    always_comb begin
        w_q_d         = r_q;
        w_cnt_d       = r_cnt;
        w_word_done_d = 1'b0;

        if (enable) begin
            case (mode)
                c_MODE_SHIFT: begin
                    w_q_d = leftright ? {r_q[WIDTH-2:0], in}
                                      : {in, r_q[WIDTH-1:1]};
                end
                c_MODE_ROTATE: begin
                    w_q_d = leftright ? {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                                      : {r_q[0], r_q[WIDTH-1:1]};
                end
                c_MODE_LOAD: begin
                    w_q_d   = load_data;
                    w_cnt_d = '0;
                end
                default: begin
                    w_q_d = r_q;
                end
            endcase

            // Shifts and rotates both advance the word counter; direction
            // changes do not disturb it.
            if ((mode == c_MODE_SHIFT) || (mode == c_MODE_ROTATE)) begin
                if (r_cnt == c_LAST_COUNT) begin
                    w_cnt_d       = '0;
                    w_word_done_d = 1'b1;
                end else begin
                    w_cnt_d       = r_cnt + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q         <= RESET_VALUE;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_q         <= w_q_d;
            r_cnt       <= w_cnt_d;
            r_word_done <= w_word_done_d;
        end
    end

`ifdef SSR_PARITY_EN
    logic r_parity;

    // Parity of the next register value, so it tracks q on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= ^RESET_VALUE;
        end else if (enable) begin
            r_parity <= ^w_q_d;
        end
    end

    assign parity = r_parity;
`endif

    assign q           = r_q;
    assign shift_count = r_cnt;
    assign word_done   = r_word_done;
    assign out         = leftright ? r_q[WIDTH-1] : r_q[0];

    // Keep the unused-mode constant referenced for readability of the case.
    logic w_unused_hold;
    assign w_unused_hold = (c_MODE_HOLD == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_register
//  Description : Self-checking bench for universal_shift_register. A table of
//                directed vectors drives the WIDTH=8 instance; hand-written
//                sequences cover combinational direction switching, a WIDTH=5
//                instance with a non-zero reset value, and optional parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic       rst, en, lr, sin;
    logic [1:0] md;
    logic [7:0] ld;
    logic       out8;
    logic [7:0] q8;
    logic [2:0] cnt8;
    logic       wd8;
`ifdef SSR_PARITY_EN
    logic       par8;
`endif

    // WIDTH=5 instance signals
    logic       rst5, en5, lr5, sin5;
    logic [1:0] md5;
    logic [4:0] ld5;
    logic       out5;
    logic [4:0] q5;
    logic [2:0] cnt5;
    logic       wd5;
`ifdef SSR_PARITY_EN
    logic       par5;
`endif

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut8 (
        .clock       (clk),
        .reset       (rst),
        .enable      (en),
        .mode        (md),
        .leftright   (lr),
        .in          (sin),
        .load_data   (ld),
        .out         (out8),
        .q           (q8),
        .shift_count (cnt8),
        .word_done   (wd8)
`ifdef SSR_PARITY_EN
        ,
        .parity      (par8)
`endif
    );

    universal_shift_register #(.WIDTH(5), .RESET_VALUE(5'h15)) u_dut5 (
        .clock       (clk),
        .reset       (rst5),
        .enable      (en5),
        .mode        (md5),
        .leftright   (lr5),
        .in          (sin5),
        .load_data   (ld5),
        .out         (out5),
        .q           (q5),
        .shift_count (cnt5),
        .word_done   (wd5)
`ifdef SSR_PARITY_EN
        ,
        .parity      (par5)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       lr;
        logic       sin;
        logic [7:0] ld;
        logic [7:0] eq;
        logic [2:0] ecnt;
        logic       ewd;
        logic       eout;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic l, input logic s, input logic [7:0] d,
                                input logic [7:0] xq, input logic [2:0] xc,
                                input logic xw, input logic xo);
        vec_t t;
        t.rst = r; t.en = e; t.mode = m; t.lr = l; t.sin = s; t.ld = d;
        t.eq = xq; t.ecnt = xc; t.ewd = xw; t.eout = xo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step8(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic s, input logic [7:0] d);
        rst = r; en = e; md = m; lr = l; sin = s; ld = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step5(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic s, input logic [4:0] d);
        rst5 = r; en5 = e; md5 = m; lr5 = l; sin5 = s; ld5 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; en = 1; md = 2'b01; lr = 1; sin = 1; ld = 8'h00;
        rst5 = 1; en5 = 1; md5 = 2'b00; lr5 = 1; sin5 = 0; ld5 = 5'h00;

        // Reset while shift mode is requested with in=1
        vecs.push_back(mk(1,1,2'b01,1,1,8'h00, 8'h00,3'd0,0,0));
        vecs.push_back(mk(1,1,2'b01,1,1,8'h00, 8'h00,3'd0,0,0));
        // Load 0xA5 then shift 0x3C in MSB first, leftward
        vecs.push_back(mk(0,1,2'b11,1,0,8'hA5, 8'hA5,3'd0,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h4A,3'd1,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h94,3'd2,0,1));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h29,3'd3,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h53,3'd4,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'hA7,3'd5,0,1));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h4F,3'd6,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h9E,3'd7,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h3C,3'd0,1,0));
        vecs.push_back(mk(0,1,2'b00,1,0,8'h00, 8'h3C,3'd0,0,0));
        // Rotate right a full word from 0x81
        vecs.push_back(mk(0,1,2'b11,0,0,8'h81, 8'h81,3'd0,0,1));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'hC0,3'd1,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h60,3'd2,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h30,3'd3,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h18,3'd4,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h0C,3'd5,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h06,3'd6,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h03,3'd7,0,1));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h81,3'd0,1,1));
        // Direction change mid-word keeps counting, no early strobe
        vecs.push_back(mk(0,1,2'b11,0,0,8'h81, 8'h81,3'd0,0,1));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'hC0,3'd1,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h60,3'd2,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h30,3'd3,0,0));
        vecs.push_back(mk(0,1,2'b10,1,0,8'h00, 8'h60,3'd4,0,0));
        vecs.push_back(mk(0,1,2'b10,1,0,8'h00, 8'hC0,3'd5,0,1));
        vecs.push_back(mk(0,1,2'b10,1,0,8'h00, 8'h81,3'd6,0,1));
        vecs.push_back(mk(0,1,2'b10,1,0,8'h00, 8'h03,3'd7,0,0));
        vecs.push_back(mk(0,1,2'b10,1,0,8'h00, 8'h06,3'd0,1,0));
        // Enable gating: 4 shifts, 3 idle cycles, resume
        vecs.push_back(mk(0,1,2'b11,1,0,8'h0F, 8'h0F,3'd0,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h1E,3'd1,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h3C,3'd2,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h78,3'd3,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'hF0,3'd4,0,1));
        vecs.push_back(mk(0,0,2'b01,1,1,8'h00, 8'hF0,3'd4,0,1));
        vecs.push_back(mk(0,0,2'b01,1,1,8'h00, 8'hF0,3'd4,0,1));
        vecs.push_back(mk(0,0,2'b11,1,1,8'hFF, 8'hF0,3'd4,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'hE0,3'd5,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'hC0,3'd6,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h80,3'd7,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h00,3'd0,1,0));
        vecs.push_back(mk(0,0,2'b01,1,0,8'h00, 8'h00,3'd0,0,0));
        // Load on the cycle the count would complete the word
        vecs.push_back(mk(0,1,2'b11,1,0,8'h00, 8'h00,3'd0,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h01,3'd1,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h03,3'd2,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h07,3'd3,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h0F,3'd4,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h1F,3'd5,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h3F,3'd6,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h7F,3'd7,0,0));
        vecs.push_back(mk(0,1,2'b11,1,1,8'h55, 8'h55,3'd0,0,0));
        vecs.push_back(mk(0,1,2'b00,1,1,8'h00, 8'h55,3'd0,0,0));
        // Reset at count 5 abandons the word
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'hAB,3'd1,0,1));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h57,3'd2,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'hAF,3'd3,0,1));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h5F,3'd4,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'hBF,3'd5,0,1));
        vecs.push_back(mk(1,1,2'b01,1,1,8'h00, 8'h00,3'd0,0,0));
        vecs.push_back(mk(0,1,2'b01,1,1,8'h00, 8'h01,3'd1,0,0));

        foreach (vecs[i]) begin
            step8(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].lr, vecs[i].sin, vecs[i].ld);
            chk($sformatf("v%0d q", i),     32'(q8),   32'(vecs[i].eq));
            chk($sformatf("v%0d count", i), 32'(cnt8), 32'(vecs[i].ecnt));
            chk($sformatf("v%0d wdone", i), 32'(wd8),  32'(vecs[i].ewd));
            chk($sformatf("v%0d out", i),   32'(out8), 32'(vecs[i].eout));
        end

        // out follows leftright combinationally, with no clock edge
        step8(0, 1, 2'b11, 1, 0, 8'h55);
        chk("dir out left", 32'(out8), 32'd0);
        lr = 1'b0;
        #1;
        chk("dir out right", 32'(out8), 32'd1);
        lr = 1'b1;
        #1;
        chk("dir out left again", 32'(out8), 32'd0);
        step8(0, 1, 2'b00, 1, 0, 8'h00);

        // WIDTH=5 with RESET_VALUE=0x15: strobe every 5 shifts
        step5(1, 1, 2'b01, 1, 1, 5'h00);
        chk("w5 reset q", 32'(q5), 32'h15);
        chk("w5 reset count", 32'(cnt5), 32'd0);
        chk("w5 reset wdone", 32'(wd5), 32'd0);
        chk("w5 reset out", 32'(out5), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            step5(0, 1, 2'b01, 1, 1, 5'h00);
            if (i == 1) chk("w5 first shift q", 32'(q5), 32'h0B);
            chk($sformatf("w5 shift%0d count", i), 32'(cnt5), 32'(i % 5));
            chk($sformatf("w5 shift%0d wdone", i), 32'(wd5), ((i % 5) == 0) ? 32'd1 : 32'd0);
        end
        step5(0, 1, 2'b00, 1, 1, 5'h00);
        chk("w5 hold wdone", 32'(wd5), 32'd0);

`ifdef SSR_PARITY_EN
        step8(0, 1, 2'b11, 1, 0, 8'h07);
        chk("parity load 07", 32'(par8), 32'd1);
        step8(0, 1, 2'b01, 1, 1, 8'h00);
        chk("parity shift q", 32'(q8), 32'h0F);
        chk("parity shift", 32'(par8), 32'd0);
        step8(0, 0, 2'b11, 1, 0, 8'h01);
        chk("parity hold", 32'(par8), 32'd0);
        step8(0, 1, 2'b11, 1, 0, 8'h01);
        chk("parity load 01", 32'(par8), 32'd1);
        step8(1, 1, 2'b00, 1, 0, 8'h00);
        chk("parity reset", 32'(par8), 32'd0);
        step5(1, 1, 2'b00, 1, 0, 5'h00);
        chk("w5 parity reset", 32'(par5), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
